conv_window_ctrl: RTL

Frame sequencer for the 3x3-window image buffer in the convolution datapath. On a `start` request it walks every window position of an IMG_W x IMG_H output frame in raster order. It drives the buffer's `rd` strobe and read coordinates, and issues the matching `wr` strobe and write coordinates exactly LAT cycles later, once the filter result is valid. It sits between the top-level frame scheduler (start/done handshake) and the buffer/filter pipeline, and replaces the buffer's free-running internal counters as the single source of addressing.

---
 rtl/conv_window_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster-order 3x3 window read sequencer with a
// fixed-latency write-back pipe for the convolution image buffer.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             frame request (taken only when idle)
//   hold              read-issue backpressure (WINCTRL_HOLD_EN only)
//   rd, rd_row/col    window read strobe and top-left coordinate
//   wr, wr_row/col    result write strobe and coordinate, LAT after rd
//   busy, done        frame in progress / one-cycle completion pulse
//   frame_cnt         completed frame count, wraps at 256
//
// Build option: define WINCTRL_HOLD_EN to honour hold in RUN.
module conv_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int LAT   = 3,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          hold,
  output logic          rd,
  output logic [CW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  output logic          wr,
  output logic [CW-1:0] wr_row,
  output logic [CW-1:0] wr_col,
  output logic          busy,
  output logic          done,
  output logic [7:0]    frame_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

  logic [1:0]    state_q;
  logic [CW-1:0] row_q;
  logic [CW-1:0] col_q;

  logic st_idle;
  logic st_run;
  logic st_drain;
  logic st_done;

  assign st_idle  = (state_q == S_IDLE);
  assign st_run   = (state_q == S_RUN);
  assign st_drain = (state_q == S_DRAIN);
  assign st_done  = (state_q == S_DONE);

  logic hold_act;

`ifdef WINCTRL_HOLD_EN
  assign hold_act = hold && st_run;
`else
  assign hold_act = 1'b0;
  logic unused_hold;
  assign unused_hold = hold;
`endif

  // The first window is issued on the same edge that accepts start,
  // so the counters read as zero while idle.
  logic          issue;
  logic [CW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic          col_end;
  logic          last;
  logic [CW-1:0] nxt_row;
  logic [CW-1:0] nxt_col;

  assign issue   = ((st_idle && start) || st_run) && !hold_act;
  assign cur_row = st_idle ? '0 : row_q;
  assign cur_col = st_idle ? '0 : col_q;
  assign col_end = (cur_col == COL_LAST);
  assign last    = col_end && (cur_row == ROW_LAST);
  assign nxt_col = col_end ? '0 : cur_col + CW'(1);
  assign nxt_row = col_end ? cur_row + CW'(1) : cur_row;

  // Pipe valids: stage 0 is the registered rd itself.
  logic [LAT:1] pv_q;
  logic [LAT:0] v_in;
  logic         pipe_live;

  assign v_in      = {pv_q, rd};
  assign pipe_live = |v_in[LAT-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      rd        <= 1'b0;
      rd_row    <= '0;
      rd_col    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rd   <= issue;
      done <= 1'b0;
      if (issue) begin
        rd_row <= cur_row;
        rd_col <= cur_col;
        row_q  <= nxt_row;
        col_q  <= nxt_col;
      end
      unique case (1'b1)
        st_idle: begin
          if (start) begin
            state_q <= S_RUN;
            busy    <= 1'b1;
          end
        end
        st_run: begin
          if (issue && last) begin
            state_q <= S_DRAIN;
          end
        end
        st_drain: begin
          if (!pipe_live) begin
            state_q   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        st_done: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Coordinates only move with a valid entry, so the last stage
  // keeps the most recent write address while wr is low.
  logic [CW-1:0] pr_q [1:LAT];
  logic [CW-1:0] pc_q [1:LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 1; i <= LAT; i++) begin
        pr_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else begin
      pv_q <= v_in[LAT-1:0];
      if (rd) begin
        pr_q[1] <= rd_row;
        pc_q[1] <= rd_col;
      end
      for (int i = 2; i <= LAT; i++) begin
        if (pv_q[i-1]) begin
          pr_q[i] <= pr_q[i-1];
          pc_q[i] <= pc_q[i-1];
        end
      end
    end
  end

  assign wr     = pv_q[LAT];
  assign wr_row = pr_q[LAT];
  assign wr_col = pc_q[LAT];

endmodule
